// File: rtl/general_register_bank_if.sv
// Register-bus bundle between a bus master and the general register bank.
interface general_register_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  read_flag;
  logic                  write_flag;
  logic [ADDR_WIDTH-1:0] amba_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  err;

  modport master (
    output read_flag, write_flag, amba_addr, data_in,
    input  data_out, rd_valid, err
  );

  modport slave (
    input  read_flag, write_flag, amba_addr, data_in,
    output data_out, rd_valid, err
  );
endinterface

// File: rtl/general_register_bank.sv
// Decoded bank of NUM_REGS registers at [BASE_ADDR, BASE_ADDR+NUM_REGS), 1-cycle registered read.
// Optional sticky write lock on the top register is enabled by defining REG_LOCK_EN.
module general_register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  parameter int BASE_ADDR  = 0
) (
  input logic SYS_CLK,
  input logic rst,
  general_register_bank_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] BASE_EXT = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] TOP_EXT  = (ADDR_WIDTH+1)'(BASE_ADDR + NUM_REGS);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH:0]   addr_ext;
  logic [IDX_W-1:0]      idx;
  logic                  hit;
  logic                  wr_ok;
  logic                  err_nxt;
  logic [DATA_WIDTH-1:0] rd_dat;

`ifdef REG_LOCK_EN
  logic locked;
  logic lock_set;
`endif

  // Extra MSB keeps the top-of-window compare from wrapping at the end of the address space.
  assign addr_ext = {1'b0, bus.amba_addr};
  assign hit      = (addr_ext >= BASE_EXT) && (addr_ext < TOP_EXT);
  assign idx      = IDX_W'(addr_ext - BASE_EXT);

  always_comb begin
    wr_ok   = 1'b0;
    err_nxt = 1'b0;
    rd_dat  = '0;
    if (bus.read_flag) begin
      rd_dat  = hit ? regs[idx] : '0;
      err_nxt = !hit || bus.write_flag;
    end else if (bus.write_flag) begin
`ifdef REG_LOCK_EN
      wr_ok   = hit && !locked;
`else
      wr_ok   = hit;
`endif
      err_nxt = !wr_ok;
    end
  end

`ifdef REG_LOCK_EN
  assign lock_set = wr_ok && (idx == LAST_IDX) && bus.data_in[0];

  always_ff @(posedge SYS_CLK) begin
    if (rst) locked <= 1'b0;
    else if (lock_set) locked <= 1'b1;
  end
`endif

  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.rd_valid <= bus.read_flag;
      bus.err      <= err_nxt;
      if (bus.read_flag) bus.data_out <= rd_dat;
      if (wr_ok)         regs[idx]    <= bus.data_in;
    end
  end

`ifndef REG_LOCK_EN
  logic unused_last;
  assign unused_last = ^LAST_IDX;
`endif
endmodule

// File: tb/tb_general_register_bank.sv
// Directed-vector scoreboard bench for general_register_bank (window 0x20..0x2F).
module tb_general_register_bank;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam int BA = 32'h20;

  typedef struct packed {
    logic          vld;
    logic          err;
    logic [DW-1:0] dat;
  } exp_t;

  logic SYS_CLK = 1'b0;
  logic rst     = 1'b1;
  int   errors  = 0;
  int   checks  = 0;
  exp_t exp_q [$];

  general_register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  general_register_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BA)
  ) dut (
    .SYS_CLK(SYS_CLK),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge SYS_CLK);
      #1;
      if (bus.rd_valid || bus.err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: rd_valid=%0b err=%0b data_out=%02h, required no strobe",
                   bus.rd_valid, bus.err, bus.data_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.rd_valid !== e.vld || bus.err !== e.err ||
              (e.vld && bus.data_out !== e.dat)) begin
            errors++;
            $display("FAIL strobe: got vld=%0b err=%0b data=%02h, required vld=%0b err=%0b data=%02h",
                     bus.rd_valid, bus.err, bus.data_out, e.vld, e.err, e.dat);
          end
        end
      end
    end
  end

  task automatic issue(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rs, input logic push, input exp_t e);
    @(negedge SYS_CLK);
    rst            = rs;
    bus.read_flag  = r;
    bus.write_flag = w;
    bus.amba_addr  = a;
    bus.data_in    = d;
    if (push) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input logic exp_e);
    issue(1'b1, 1'b0, a, '0, 1'b0, 1'b1, {1'b1, exp_e, exp_d});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_e);
    issue(1'b0, 1'b1, a, d, 1'b0, exp_e, {1'b0, 1'b1, 8'h00});
  endtask

  task automatic both(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] exp_d);
    issue(1'b1, 1'b1, a, d, 1'b0, 1'b1, {1'b1, 1'b1, exp_d});
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h", name, got, req);
    end
  endtask

  initial begin
    bus.read_flag  = 1'b0;
    bus.write_flag = 1'b0;
    bus.amba_addr  = '0;
    bus.data_in    = '0;
    repeat (3) @(negedge SYS_CLK);
    rst = 1'b0;
    chk("reset_data_out", bus.data_out, 8'h00);
    chk("reset_rd_valid", {7'd0, bus.rd_valid}, 8'h00);
    chk("reset_err", {7'd0, bus.err}, 8'h00);

    for (int i = 0; i < NR; i++) rd(AW'(BA + i), 8'h00, 1'b0);

    wr(8'h23, 8'hA5, 1'b0);
    rd(8'h23, 8'hA5, 1'b0);
    idle(2);
    chk("idle_hold_data_out", bus.data_out, 8'hA5);
    chk("idle_no_rd_valid", {7'd0, bus.rd_valid}, 8'h00);

    rd(8'h30, 8'h00, 1'b1);
    wr(8'h30, 8'h77, 1'b1);
    rd(8'h1F, 8'h00, 1'b1);
    rd(8'hFF, 8'h00, 1'b1);
    rd(8'h20, 8'h00, 1'b0);
    wr(8'h2F, 8'h3C, 1'b0);
    rd(8'h2F, 8'h3C, 1'b0);
    rd(8'h23, 8'hA5, 1'b0);
    rd(8'h2E, 8'h00, 1'b0);

    wr(8'h22, 8'h11, 1'b0);
    both(8'h22, 8'h22, 8'h11);
    rd(8'h22, 8'h11, 1'b0);
    idle(2);

    rd(8'h23, 8'hA5, 1'b0);
    issue(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    idle(1);
    chk("rst_after_read_data_out", bus.data_out, 8'h00);
    chk("rst_after_read_rd_valid", {7'd0, bus.rd_valid}, 8'h00);

    wr(8'h24, 8'h66, 1'b0);
    issue(1'b1, 1'b0, 8'h24, '0, 1'b1, 1'b0, '0);
    idle(1);
    chk("rst_discard_rd_valid", {7'd0, bus.rd_valid}, 8'h00);
    chk("rst_discard_data_out", bus.data_out, 8'h00);
    for (int i = 0; i < NR; i++) rd(AW'(BA + i), 8'h00, 1'b0);

`ifdef REG_LOCK_EN
    wr(AW'(BA + NR - 1), 8'h01, 1'b0);
    wr(AW'(BA), 8'h5A, 1'b1);
    rd(AW'(BA), 8'h00, 1'b0);
    wr(AW'(BA + NR - 1), 8'h00, 1'b1);
    rd(AW'(BA + NR - 1), 8'h01, 1'b0);
    issue(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    wr(AW'(BA), 8'h5A, 1'b0);
    rd(AW'(BA), 8'h5A, 1'b0);
`endif

    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
